// File: rtl/birth_seq_pkg.sv
// birth_seq_pkg: shared state enum, default date digits and seven-segment table for birth_seq_gen
package birth_seq_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int DEFAULT_DIGITS [8] = '{1, 9, 9, 7, 0, 7, 2, 8};
  localparam logic [6:0] SEG_LUT [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
endpackage

// File: rtl/birth_seq_table.sv
// birth_seq_table: DEPTH x DIGIT_W digit register file, reset-loaded with the date sequence, async read
module birth_seq_table
  import birth_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DIGIT_W = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DIGIT_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [DIGIT_W-1:0] rd_data
);
  logic [DIGIT_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= DIGIT_W'(DEFAULT_DIGITS[i % 8]);
    else if (wr_en && 32'(wr_addr) < DEPTH) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/birth_seq_gen.sv
// birth_seq_gen: timed birthday-digit player (fwd/rev, one-shot/loop); BIRTH_SEQ_SEG_EN adds seg decode output
module birth_seq_gen
  import birth_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DIGIT_W = 4,
  parameter int PERIOD = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = PERIOD > 1 ? $clog2(PERIOD) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DIGIT_W-1:0] wr_data,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic               loop,
  output logic [DIGIT_W-1:0] digit,
  output logic [AW-1:0]      idx,
  output logic               valid,
  output logic               busy,
  output logic               done
`ifdef BIRTH_SEQ_SEG_EN
  ,
  output logic [6:0]         seg
`endif
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_t state, state_nx;
  logic [AW-1:0] idx_nx;
  logic [DW-1:0] div, div_nx;
  logic dir_q, loop_q, dir_nx, loop_nx, done_nx, last, tick;
  logic [DIGIT_W-1:0] rd_data;
  birth_seq_table #(.DEPTH(DEPTH), .DIGIT_W(DIGIT_W), .AW(AW)) u_table (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(idx), .rd_data(rd_data)
  );
  assign last = dir_q ? idx == '0 : idx == LAST;
  assign tick = div == DW'(PERIOD - 1);
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    div_nx = div;
    dir_nx = dir_q;
    loop_nx = loop_q;
    done_nx = 1'b0;
    if (stop) state_nx = IDLE;
    else if (start) begin
      state_nx = RUN;
      idx_nx = dir ? LAST : '0;
      div_nx = '0;
      dir_nx = dir;
      loop_nx = loop;
    end else if (state == RUN) begin
      div_nx = tick ? '0 : div + 1'b1;
      if (tick && last && !loop_q) begin
        state_nx = IDLE;
        done_nx = 1'b1;
      end else if (tick) idx_nx = last ? (dir_q ? LAST : '0) : (dir_q ? idx - 1'b1 : idx + 1'b1);
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      div <= '0;
      dir_q <= 1'b0;
      loop_q <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      div <= div_nx;
      dir_q <= dir_nx;
      loop_q <= loop_nx;
      done <= done_nx;
    end
  assign busy = state == RUN;
  assign valid = busy;
  assign digit = valid ? rd_data : '0;
`ifdef BIRTH_SEQ_SEG_EN
  logic [3:0] d4;
  assign d4 = 4'(digit);
  assign seg = (valid && 32'(digit) < 10) ? SEG_LUT[d4] : 7'd0;
`endif
endmodule

// File: tb/tb_birth_seq_gen.sv
// tb_birth_seq_gen: directed stimulus with per-cycle behavioural model check of birth_seq_gen
module tb_birth_seq_gen;
  localparam int DEPTH = 8, DIGIT_W = 4, PERIOD = 4, AW = 3;
  logic clk = 0, rst = 1, wr_en = 0, start = 0, stop = 0, dir = 0, loop = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DIGIT_W-1:0] wr_data = '0;
  logic [DIGIT_W-1:0] digit;
  logic [AW-1:0] idx;
  logic valid, busy, done;
`ifdef BIRTH_SEQ_SEG_EN
  logic [6:0] seg;
  logic [6:0] seg_lit [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
`endif
  int n_chk = 0, n_pass = 0;
  int defs [8] = '{1, 9, 9, 7, 0, 7, 2, 8};
  int lit_fwd [8] = '{1, 9, 9, 7, 0, 7, 2, 8};
  int lit_rev [8] = '{8, 2, 7, 0, 7, 9, 9, 1};
  always #5 clk = ~clk;
  birth_seq_gen #(.DEPTH(DEPTH), .DIGIT_W(DIGIT_W), .PERIOD(PERIOD)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .dir(dir), .loop(loop),
    .digit(digit), .idx(idx), .valid(valid), .busy(busy), .done(done)
`ifdef BIRTH_SEQ_SEG_EN
    , .seg(seg)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask
  logic s_rst, s_wr_en, s_start, s_stop, s_dir, s_loop;
  logic [AW-1:0] s_wr_addr;
  logic [DIGIT_W-1:0] s_wr_data;
  always @(posedge clk) begin
    s_rst <= rst;
    s_wr_en <= wr_en;
    s_wr_addr <= wr_addr;
    s_wr_data <= wr_data;
    s_start <= start;
    s_stop <= stop;
    s_dir <= dir;
    s_loop <= loop;
  end
  int tab [DEPTH];
  bit m_run, m_dir, m_loop, m_done;
  int m_t, m_hold;
  function automatic int cur_idx();
    int pos;
    pos = (m_t / PERIOD) % DEPTH;
    if (!m_run) return m_hold;
    return m_dir ? DEPTH - 1 - pos : pos;
  endfunction
  initial forever begin
    @(negedge clk);
    if (s_rst) begin
      m_run = 0; m_t = 0; m_hold = 0; m_done = 0;
      for (int i = 0; i < DEPTH; i++) tab[i] = defs[i % 8];
    end else begin
      m_done = 0;
      if (s_wr_en && 32'(s_wr_addr) < DEPTH) tab[s_wr_addr] = int'(s_wr_data);
      if (s_stop) begin
        m_hold = cur_idx();
        m_run = 0;
      end else if (s_start) begin
        m_run = 1; m_t = 0; m_dir = s_dir; m_loop = s_loop;
      end else if (m_run) begin
        m_t++;
        if (!m_loop && m_t == DEPTH * PERIOD) begin
          m_run = 0; m_done = 1; m_hold = m_dir ? 0 : DEPTH - 1;
        end
      end
    end
    chk("m_busy", busy, m_run);
    chk("m_valid", valid, m_run);
    chk("m_done", done, m_done);
    chk("m_idx", idx, cur_idx());
    chk("m_digit", digit, m_run ? tab[cur_idx()] : 0);
`ifdef BIRTH_SEQ_SEG_EN
    chk("m_seg", seg, (m_run && tab[cur_idx()] < 10) ? seg_lit[tab[cur_idx()]] : 0);
`endif
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic go(input logic d, input logic l);
    start = 1; dir = d; loop = l;
    step(1);
    start = 0;
  endtask
  initial begin
    int nb, nd, dc;
    step(2);
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_digit", digit, 0);
    chk("rst_idx", idx, 0);
    chk("rst_done", done, 0);
    go(0, 0);
    nb = 0; nd = 0; dc = -1;
    for (int c = 0; c < 40; c++) begin
      if (c % 4 == 0 && c < 32) chk("fwd_digit", digit, lit_fwd[c / 4]);
      nb += int'(busy);
      if (done) begin nd++; dc = c; end
      step(1);
    end
    chk("fwd_busy_cycles", nb, 32);
    chk("fwd_done_count", nd, 1);
    chk("fwd_done_cycle", dc, 32);
    chk("fwd_valid_after", valid, 0);
    go(1, 1);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 4 == 0) chk("rev_digit", digit, lit_rev[(c / 4) % 8]);
      if (c == 28) chk("rev_idx_pre_wrap", idx, 0);
      if (c == 32) chk("rev_idx_wrap", idx, 7);
      nd += int'(done);
      step(1);
    end
    chk("rev_no_done", nd, 0);
    stop = 1; step(1); stop = 0;
    go(0, 1);
    step(12);
    chk("wr_idx3", idx, 3);
    chk("wr_before", digit, 7);
    wr_en = 1; wr_addr = 3; wr_data = 5;
    step(1);
    wr_en = 0;
    chk("wr_after", digit, 5);
    step(31);
    chk("wr_next_pass", digit, 5);
    stop = 1; step(1); stop = 0;
    go(0, 0);
    step(10);
    stop = 1; step(1); stop = 0;
    chk("stop_valid", valid, 0);
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    chk("stop_idx", idx, 2);
    go(0, 0);
    step(5);
    rst = 1; step(1); rst = 0;
    chk("mrst_busy", busy, 0);
    chk("mrst_digit", digit, 0);
    chk("mrst_idx", idx, 0);
    go(0, 0);
    step(12);
    chk("mrst_table", digit, 7);
    step(8);
    chk("restart_pre_idx", idx, 5);
    go(0, 0);
    chk("restart_idx", idx, 0);
    chk("restart_digit", digit, 1);
    step(3);
    chk("restart_hold", idx, 0);
    step(1);
    chk("restart_adv", idx, 1);
    stop = 1; start = 1; step(1); stop = 0; start = 0;
    chk("stop_start_busy", busy, 0);
`ifdef BIRTH_SEQ_SEG_EN
    go(0, 0);
    step(12);
    chk("seg_7", seg, 7'b0000111);
    step(4);
    chk("seg_0", seg, 7'b0111111);
    stop = 1; wr_en = 1; wr_addr = 0; wr_data = 12; step(1); stop = 0; wr_en = 0;
    go(0, 0);
    chk("seg_12_digit", digit, 12);
    chk("seg_12_blank", seg, 0);
`endif
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/birth_seq_gen.md
# birth_seq_gen

Sequential birthday-digit player: holds a DEPTH-entry table of DIGIT_W-bit digits, reset-loaded with the team's date sequence 1,9,9,7,0,7,2,8, and steps through it one digit every PERIOD clocks. It supports forward or reverse order, one-shot or looping playback, and runtime rewriting of table entries. It sits between the lab switch/button front end and the digit display driver, replacing the fixed 3-bit→4-bit combinational digit lookup.

## Interface
- DEPTH, 8, number of table entries (≥2); AW = $clog2(DEPTH)
- DIGIT_W, 4, width of each digit
- PERIOD, 4, clock cycles each digit is held (≥1)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write table entry this cycle
- wr_addr  in  AW  entry to write (values ≥DEPTH ignored)
- wr_data  in  DIGIT_W  data to write
- start  in  1  begin playback (sampled per cycle)
- stop  in  1  abort playback
- dir  in  1  0 = forward (0→DEPTH-1), 1 = reverse; latched at start
- loop  in  1  1 = wrap and repeat, 0 = one-shot; latched at start
- digit  out  DIGIT_W  table[idx] while valid, else 0
- idx  out  AW  current table index
- valid  out  1  digit is meaningful
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse at natural end of a one-shot pass

## Operation
- Reset: state IDLE, idx=0, divider=0, valid=0, busy=0, done=0, digit=0; table[i] = default[i mod 8], default = 1,9,9,7,0,7,2,8.
- FSM states: IDLE, RUN. Priority per cycle: rst > stop > start > normal advance.
- IDLE + start: → RUN; idx = 0 (dir=0) or DEPTH-1 (dir=1); divider=0; latch dir, loop.
- RUN + start (no stop): restart exactly as from IDLE; no done pulse.
- RUN + stop: → IDLE, valid=0, idx unchanged, no done pulse.
- RUN: divider counts 0..PERIOD-1. When it reaches PERIOD-1, it resets to 0 and idx advances by ±1.
- At the terminal index (DEPTH-1 forward, 0 reverse) with divider=PERIOD-1:
  - loop=1: wrap to 0 / DEPTH-1.
  - loop=0: → IDLE, valid=0, done=1 for exactly one cycle.
- idx arithmetic is explicit compare-and-wrap, correct for non-power-of-2 DEPTH.
- Writes are accepted in any state, including during RUN and on the same cycle as start or stop. They are never blocked. A write to the displayed index changes digit from the next cycle.
- Simultaneous write and rst: rst wins and the table reloads defaults.

## Timing
- start sampled at edge k: busy=1, valid=1, digit=table[first] visible after edge k.
- Each index is visible for exactly PERIOD cycles. A one-shot pass has busy=1 for DEPTH·PERIOD cycles, then done=1 in the first IDLE cycle.
- digit is combinational from registered idx and table. valid, busy, done, and idx are registered.
- stop at edge k: valid=0 after edge k.
- Reset in mid-RUN returns every output to its reset value after that edge.

## Configuration
- BIRTH_SEQ_SEG_EN defined: adds output seg (7 bits, active-high, order g..a). seg is a combinational decode of digit for 0–9; blank (0) for values >9 or when valid=0.
- BIRTH_SEQ_SEG_EN undefined: no seg port and no decoder logic; all other behaviour is identical.

## Structure
- Package birth_seq_pkg holds:
  - the state enum (IDLE, RUN)
  - the 8-entry default digit constant
  - the 10-entry seven-segment constant
- Sub-module birth_seq_table holds the DEPTH×DIGIT_W register file: synchronous write, reset-to-default, asynchronous read port.
- The top level contains the FSM, the divider, the idx counter, and the optional seg decode.

## Test plan
- Reset, then start, dir=0, loop=0, defaults → digits 1,9,9,7,0,7,2,8, each held 4 cycles; busy for 32 cycles; done=1 for one cycle; then valid=0.
- start with dir=1, loop=1 → 8,2,7,0,7,9,9,1,8,2,…; wraps with no done pulse; idx goes 0→7 on wrap.
- Write table[3]=5 during RUN while idx=3 → digit 7 changes to 5 on the next cycle; a later pass shows 1,9,9,5,….
- stop at cycle 10 of a pass → valid=0 and busy=0 next cycle, no done; rst on a later mid-pass cycle → all outputs 0 and table reverts to 1,9,9,7,….
- start asserted mid-pass (idx=5) → idx=0, divider restarts, digit=1 next cycle; stop and start in the same cycle → IDLE.
- With BIRTH_SEQ_SEG_EN defined: digit 7 → seg 7'b0000111; digit 0 → seg 7'b0111111; write 12 → seg 0.
